// File: rtl/mem_port_arbiter_if.sv
`timescale 1ns/1ps
// mem_port_arbiter_if: fetch-port, data-port and memory-side signals of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline/memory driving it.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req, if_valid, dm_req, dm_we, dm_valid;
   logic              mem_en, mem_we, mem_ready, stall, err;
   logic [ADDR_W-1:0] if_addr, dm_addr, mem_addr;
   logic [DATA_W-1:0] if_rdata, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_valid, dm_rdata, dm_valid, mem_en, mem_we, mem_addr, mem_wdata, stall, err
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_valid, dm_rdata, dm_valid, mem_en, mem_we, mem_addr, mem_wdata, stall, err
   );
endinterface

// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one memory port between instruction fetch and data access,
// alternating on contention. Define ARB_TIMEOUT_EN to add the mem_ready watchdog and sticky err.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2;
   logic [1:0]        state;
   logic              last_d, we_q, busy, grant_d, grant_i, done, expired;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   assign busy    = state != IDLE;
   // data wins contention unless it won the previous grant
   assign grant_d = bus.dm_req & (~bus.if_req | ~last_d);
   assign grant_i = bus.if_req & ~grant_d;
`ifdef ARB_TIMEOUT_EN
   logic [7:0] cnt;
   assign expired = busy & ~bus.mem_ready & (cnt == 8'(TIMEOUT - 1));
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt     <= '0;
         bus.err <= 1'b0;
      end else begin
         cnt <= (busy & ~bus.mem_ready & ~expired) ? cnt + 8'd1 : 8'd0;
         if (expired) bus.err <= 1'b1;
      end
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign expired = 1'b0;
   assign bus.err = 1'b0;
`endif
   assign done = busy & (bus.mem_ready | expired);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state        <= IDLE;
         last_d       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         bus.if_rdata <= '0;
         bus.if_valid <= 1'b0;
         bus.dm_rdata <= '0;
         bus.dm_valid <= 1'b0;
      end else begin
         bus.if_valid <= (state == BUSY_I) && done;
         bus.dm_valid <= (state == BUSY_D) && done;
         if (state == BUSY_I && bus.mem_ready) bus.if_rdata <= bus.mem_rdata;
         if (state == BUSY_D && bus.mem_ready && !we_q) bus.dm_rdata <= bus.mem_rdata;
         if (done) state <= IDLE;
         else if (state == IDLE && (grant_d || grant_i)) begin
            state   <= grant_d ? BUSY_D : BUSY_I;
            last_d  <= grant_d;
            addr_q  <= grant_d ? bus.dm_addr : bus.if_addr;
            we_q    <= bus.dm_we;
            wdata_q <= bus.dm_wdata;
         end
      end
   assign bus.mem_en    = busy;
   assign bus.mem_we    = (state == BUSY_D) & we_q;
   assign bus.mem_addr  = busy ? addr_q : '0;
   assign bus.mem_wdata = busy ? wdata_q : '0;
   assign bus.stall     = (bus.if_req & ~bus.if_valid) | (bus.dm_req & ~bus.dm_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: drives fetch/data requesters and a memory with random latency, and
// checks every access against a transaction-level grant/alternation model.
module tb_mem_port_arbiter;
  localparam int AW = 32, DW = 32, TO = 15;
  logic clk = 1'b0, rst = 1'b1;
  int total = 0, bad = 0;
  bit last_d;
  logic [AW-1:0] t_if_addr, t_dm_addr;
  logic [DW-1:0] t_wdata, exp_if_rdata, exp_dm_rdata;
  logic t_we;
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // one access by side d (1 = data): grant, lat wait cycles, completion pulse
  task automatic do_access(input bit d, input int lat, input bit drop, input logic [DW-1:0] rd);
    logic [AW-1:0] ea;
    logic ewe;
    bit es;
    ea  = d ? t_dm_addr : t_if_addr;
    ewe = d & t_we;
    tick;
    total++;
    if (bus.mem_en !== 1'b1 || bus.mem_addr !== ea || bus.mem_we !== ewe || bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL grant: en=%b addr=%h we=%b stall=%b, want en=1 addr=%h we=%b stall=1",
               bus.mem_en, bus.mem_addr, bus.mem_we, bus.stall, ea, ewe);
    end
    if (ewe) begin
      total++;
      if (bus.mem_wdata !== t_wdata) begin
        bad++;
        $display("FAIL wdata: got %h want %h", bus.mem_wdata, t_wdata);
      end
    end
    if (drop) begin
      if (d) bus.dm_req = 1'b0;
      else bus.if_req = 1'b0;
    end
    repeat (lat) begin
      tick;
      total++;
      if (bus.mem_en !== 1'b1 || bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0) begin
        bad++;
        $display("FAIL wait: en=%b iv=%b dv=%b, want en=1 iv=0 dv=0", bus.mem_en, bus.if_valid, bus.dm_valid);
      end
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rd;
    tick;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = $urandom;
    if (!d) exp_if_rdata = rd;
    else if (!t_we) exp_dm_rdata = rd;
    total++;
    if ({bus.if_valid, bus.dm_valid} !== (d ? 2'b01 : 2'b10) || bus.mem_en !== 1'b0 ||
        bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata) begin
      bad++;
      $display("FAIL done: iv=%b dv=%b en=%b ird=%h drd=%h, want side=%0d en=0 ird=%h drd=%h",
               bus.if_valid, bus.dm_valid, bus.mem_en, bus.if_rdata, bus.dm_rdata, d, exp_if_rdata, exp_dm_rdata);
    end
    es = (bus.if_req && d) || (bus.dm_req && !d);
    total++;
    if (bus.stall !== es) begin
      bad++;
      $display("FAIL stall_done: got %b want %b", bus.stall, es);
    end
    if (d) bus.dm_req = 1'b0;
    else bus.if_req = 1'b0;
  endtask
  // pat[0] = fetch request, pat[1] = data request, raised together from IDLE
  task automatic round(input logic [1:0] pat, input bit rnd, input logic [DW-1:0] rd0);
    bit first;
    bus.if_addr  = t_if_addr;
    bus.dm_addr  = t_dm_addr;
    bus.dm_we    = t_we;
    bus.dm_wdata = t_wdata;
    bus.if_req   = pat[0];
    bus.dm_req   = pat[1];
    #1;
    total++;
    if (bus.stall !== 1'b1 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL request: stall=%b en=%b, want stall=1 en=0", bus.stall, bus.mem_en);
    end
    first = (pat == 2'b11) ? !last_d : pat[1];
    if (rnd) do_access(first, $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom);
    else do_access(first, 0, 1'b0, rd0);
    last_d = first;
    if (pat == 2'b11) begin
      do_access(!first, rnd ? $urandom_range(0, 3) : 0, 1'b0, $urandom);
      last_d = !first;
    end
    bus.mem_ready = 1'b1;
    bus.mem_rdata = $urandom;
    tick;
    bus.mem_ready = 1'b0;
    total++;
    if (bus.mem_en !== 1'b0 || bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.if_rdata !== exp_if_rdata || bus.dm_rdata !== exp_dm_rdata) begin
      bad++;
      $display("FAIL idle: en=%b iv=%b dv=%b err=%b ird=%h drd=%h, want zeros ird=%h drd=%h",
               bus.mem_en, bus.if_valid, bus.dm_valid, bus.err, bus.if_rdata, bus.dm_rdata, exp_if_rdata, exp_dm_rdata);
    end
  endtask
  task automatic test_reset;
    #2;
    total++;
    if (bus.mem_en !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_addr !== '0 || bus.mem_wdata !== '0 ||
        bus.if_valid !== 1'b0 || bus.dm_valid !== 1'b0 || bus.if_rdata !== '0 || bus.dm_rdata !== '0 ||
        bus.err !== 1'b0 || bus.stall !== 1'b0) begin
      bad++;
      $display("FAIL reset: en=%b we=%b addr=%h wd=%h iv=%b dv=%b err=%b stall=%b, want all 0",
               bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.if_valid, bus.dm_valid, bus.err, bus.stall);
    end
    bus.if_req = 1'b1;
    #1;
    total++;
    if (bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL reset_stall: got %b want 1", bus.stall);
    end
    bus.if_req = 1'b0;
    tick;
    rst = 1'b0;
    last_d = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
  endtask
  task automatic test_alternate;
    t_if_addr = 32'h104; t_dm_addr = 32'h2000; t_we = 1'b0; t_wdata = 32'h1234;
    round(2'b11, 1'b0, 32'hCAFE0001);
    t_dm_addr = 32'h3000;
    round(2'b10, 1'b0, 32'hCAFE0002);
    t_if_addr = 32'h108; t_dm_addr = 32'h2004;
    round(2'b11, 1'b0, 32'hCAFE0003);
  endtask
  task automatic test_store;
    t_dm_addr = 32'h40; t_we = 1'b1; t_wdata = 32'hDEADBEEF;
    round(2'b10, 1'b0, 32'h55AA55AA);
    t_we = 1'b0;
  endtask
  task automatic test_fetch;
    t_if_addr = 32'h100;
    round(2'b01, 1'b0, 32'h00500093);
  endtask
  task automatic test_random(input int n);
    repeat (n) begin
      t_if_addr = $urandom; t_dm_addr = $urandom; t_we = 1'($urandom_range(0, 1)); t_wdata = $urandom;
      round(2'($urandom_range(1, 3)), 1'b1, '0);
    end
  endtask
  task automatic test_stuck;
    t_dm_addr = 32'h80; t_we = 1'b0;
    bus.dm_addr = t_dm_addr; bus.dm_we = 1'b0; bus.dm_req = 1'b1;
    tick;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      total++;
      if (bus.mem_en !== 1'b1 || bus.dm_valid !== 1'b0 || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL tmo_wait: cyc=%0d en=%b dv=%b err=%b, want 1 0 0", k, bus.mem_en, bus.dm_valid, bus.err);
      end
      tick;
    end
    total++;
    if (bus.dm_valid !== 1'b1 || bus.mem_en !== 1'b0 || bus.err !== 1'b1 || bus.dm_rdata !== exp_dm_rdata) begin
      bad++;
      $display("FAIL tmo_fire: dv=%b en=%b err=%b drd=%h, want 1 0 1 %h", bus.dm_valid, bus.mem_en, bus.err, bus.dm_rdata, exp_dm_rdata);
    end
    bus.dm_req = 1'b0;
    tick;
    total++;
    if (bus.dm_valid !== 1'b0 || bus.err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: dv=%b err=%b, want 0 1", bus.dm_valid, bus.err);
    end
    bus.dm_req = 1'b1;
    tick;
`else
    repeat (40) begin
      total++;
      if (bus.mem_en !== 1'b1 || bus.dm_valid !== 1'b0 || bus.err !== 1'b0) begin
        bad++;
        $display("FAIL hold: en=%b dv=%b err=%b, want 1 0 0", bus.mem_en, bus.dm_valid, bus.err);
      end
      tick;
    end
`endif
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (bus.mem_en !== 1'b0 || bus.mem_addr !== '0 || bus.dm_valid !== 1'b0 || bus.err !== 1'b0 ||
        bus.dm_rdata !== '0 || bus.stall !== 1'b1) begin
      bad++;
      $display("FAIL rst_busy: en=%b addr=%h dv=%b err=%b drd=%h stall=%b, want 0 0 0 0 0 1",
               bus.mem_en, bus.mem_addr, bus.dm_valid, bus.err, bus.dm_rdata, bus.stall);
    end
    bus.dm_req = 1'b0;
    tick;
    rst = 1'b0;
    last_d = 1'b0;
    exp_if_rdata = '0;
    exp_dm_rdata = '0;
    tick;
    total++;
    if (bus.dm_valid !== 1'b0 || bus.mem_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_after: dv=%b en=%b, want 0 0", bus.dm_valid, bus.mem_en);
    end
  endtask
  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
    test_reset;
    test_alternate;
    test_store;
    test_fetch;
    test_random(60);
    test_stuck;
    test_random(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
